// File: rtl/ofdm_pkg.sv
// Shared OFDM constants: subcarrier count, sample width and allocation codes.
// Also holds the downstream bus-cycle state type used by data_extract.
package ofdm_pkg;

  localparam int NSC = 200;
  localparam int DW  = 32;

  localparam logic [1:0] ALLOC_NULL    = 2'b00;
  localparam logic [1:0] ALLOC_PILOT_P = 2'b01;
  localparam logic [1:0] ALLOC_PILOT_N = 2'b10;
  localparam logic [1:0] ALLOC_DATA    = 2'b11;

  typedef enum logic {
    BUS_IDLE   = 1'b0,
    BUS_ACTIVE = 1'b1
  } bus_state_t;

  function automatic logic is_data_code(input logic [1:0] code);
    logic res;
    res = 1'b0;
    case (code)
      ALLOC_DATA:                              res = 1'b1;
      ALLOC_PILOT_P, ALLOC_PILOT_N, ALLOC_NULL: res = 1'b0;
      default:                                 res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Small register FIFO between the classifier and the downstream bus.
// Head is visible on dout while not empty; push and pop may coincide.
module wb_skid_fifo import ofdm_pkg::*; #(
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_reg[rd_ptr_reg];

  // Storage is cleared on reset so the head reads as zero until first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= din;
        wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/data_extract.sv
// Drops pilot/null subcarriers from the phase-tracked stream and forwards data
// subcarriers through a 2-entry FIFO onto the downstream bus.
module data_extract import ofdm_pkg::*; #(
  parameter int NSC = ofdm_pkg::NSC,
  parameter int DW  = ofdm_pkg::DW
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [DW-1:0]    DAT_I,
  input  logic             CYC_I,
  input  logic             STB_I,
  input  logic             WE_I,
  output logic             ACK_O,
  output logic [DW-1:0]    DAT_O,
  output logic             CYC_O,
  output logic             STB_O,
  output logic             WE_O,
  input  logic             ACK_I,
  input  logic [2*NSC-1:0] ALLOC_VEC,
  output logic             VEC_LD
);

  localparam int KW = (NSC > 1) ? $clog2(NSC) : 1;
  localparam int KN = 2 ** KW;

  logic [KW-1:0]    k_reg;
  logic [KW-1:0]    k_next;
  logic [2*NSC-1:0] vec_reg;
  logic [2*NSC-1:0] cur_vec;
  logic [KN-1:0]    data_map;
  logic             wr_req;
  logic             in_xfer;
  logic             sym_start;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       fifo_count;
  bus_state_t       state_reg;
  bus_state_t       state_next;

  // Index 0 is classified with the incoming vector, later indices with the latched one.
  assign cur_vec = (k_reg == '0) ? ALLOC_VEC : vec_reg;

  for (genvar gi = 0; gi < KN; gi++) begin : g_map
    if (gi < NSC) begin : g_used
      assign data_map[gi] = is_data_code(cur_vec[2*gi +: 2]);
    end else begin : g_pad
      assign data_map[gi] = 1'b0;
    end
  end

  // Acceptance depends only on FIFO occupancy, never on ACK_I.
  assign wr_req    = CYC_I & STB_I & WE_I;
  assign in_xfer   = wr_req & ~fifo_full & ~RST_I;
  assign sym_start = in_xfer & (k_reg == '0);
  assign push      = in_xfer & data_map[k_reg];
  assign pop       = STB_O & ACK_I;

  always_comb begin
    k_next = k_reg;
    if (!CYC_I) begin
      k_next = '0;
    end else if (in_xfer) begin
      k_next = (k_reg == KW'(NSC - 1)) ? '0 : k_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      k_reg   <= '0;
      vec_reg <= '0;
    end else begin
      k_reg <= k_next;
      if (sym_start) begin
        vec_reg <= ALLOC_VEC;
      end
    end
  end

  wb_skid_fifo #(
    .DW    (DW),
    .DEPTH (2)
  ) u_fifo (
    .clk   (CLK_I),
    .rst   (RST_I),
    .push  (push),
    .pop   (pop),
    .din   (DAT_I),
    .dout  (DAT_O),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_reg <= BUS_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The cycle opens with the first push so CYC_O rises together with STB_O.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BUS_IDLE:   if (push) state_next = BUS_ACTIVE;
      BUS_ACTIVE: if (!CYC_I && (fifo_count == '0)) state_next = BUS_IDLE;
      default:    state_next = BUS_IDLE;
    endcase
  end

  always_comb begin
    CYC_O  = (state_reg == BUS_ACTIVE);
    STB_O  = ~fifo_empty;
    WE_O   = ~fifo_empty;
    ACK_O  = in_xfer;
    VEC_LD = sym_start;
  end

endmodule

// File: tb/tb_data_extract.sv
// Directed bench for data_extract: symbol streams with known pilot maps,
// checked against a bench-built expected output list.
module tb_data_extract;

  localparam int N = 200;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   dat_i;
  logic           cyc_i, stb_i, we_i;
  logic           ack_o;
  logic [W-1:0]   dat_o;
  logic           cyc_o, stb_o, we_o;
  logic           ack_i;
  logic [2*N-1:0] alloc_vec;
  logic           vec_ld;

  always #5 clk = ~clk;

  data_extract #(.NSC(N), .DW(W)) dut (
    .CLK_I(clk), .RST_I(rst), .DAT_I(dat_i), .CYC_I(cyc_i), .STB_I(stb_i), .WE_I(we_i),
    .ACK_O(ack_o), .DAT_O(dat_o), .CYC_O(cyc_o), .STB_O(stb_o), .WE_O(we_o),
    .ACK_I(ack_i), .ALLOC_VEC(alloc_vec), .VEC_LD(vec_ld)
  );

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  bit ack_slow = 1'b0;
  bit cur_is_data = 1'b0;
  int stalls = 0;

  int model_occ = 0;
  int viol = 0;
  int full_cnt = 0;
  int vec_ld_cnt = 0;
  int cyc_o_hi = 0;
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];

  int got_base, exp_base, vld_base, viol_base, full_base, cyc_base, stall_base;

  logic [2*N-1:0] std_v;
  logic [2*N-1:0] ones_v;
  logic [2*N-1:0] zero_v;

  // Observe the bus one time unit before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (ack_o && model_occ == 2) viol++;
    if (model_occ == 2) full_cnt++;
    if (vec_ld) vec_ld_cnt++;
    if (cyc_o) cyc_o_hi++;
    if (stb_o && ack_i) begin
      got_q.push_back(dat_o);
      model_occ--;
    end
    if (cyc_i && stb_i && we_i && ack_o && cur_is_data) model_occ++;
    if (rst) model_occ = 0;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc_cnt++;
    ack_i = ack_slow ? ((cyc_cnt % 3) == 0) : 1'b1;
  endtask

  task automatic send(input logic [W-1:0] d, input bit isd);
    int n;
    n = 0;
    forever begin
      tick();
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = d; cur_is_data = isd;
      #2;
      if (ack_o) break;
      n++;
      stalls++;
      if (n > 60) begin
        checks++;
        failures++;
        $display("FAIL send_timeout observed=no_ack expected=ack");
        break;
      end
    end
    if (isd) exp_q.push_back(d);
  endtask

  task automatic send_k(input int run, input int sym, input int k, input logic [2*N-1:0] eff);
    logic [W-1:0] d;
    logic [1:0] code;
    d = {8'(run), 8'(sym), 16'(k)};
    code = eff[2*k +: 2];
    send(d, code == 2'b11);
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      stb_i = 1'b0; cur_is_data = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 400) begin
      tick();
      cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cur_is_data = 1'b0;
      n++;
      if ((got_q.size() - got_base) >= (exp_q.size() - exp_base)) break;
    end
    tick();
    tick();
    tick();
  endtask

  task automatic start_run();
    got_base   = got_q.size();
    exp_base   = exp_q.size();
    vld_base   = vec_ld_cnt;
    viol_base  = viol;
    full_base  = full_cnt;
    cyc_base   = cyc_o_hi;
    stall_base = stalls;
  endtask

  task automatic check_run(input string tag, input int exp_n, input int exp_vld);
    int ng, ne, mism;
    ng = got_q.size() - got_base;
    ne = exp_q.size() - exp_base;
    mism = 0;
    for (int i = 0; i < ng && i < ne; i++) begin
      if (got_q[got_base + i] !== exp_q[exp_base + i]) mism++;
    end
    chk({tag, "_out_count"}, 64'(ng), 64'(exp_n));
    chk({tag, "_model_count"}, 64'(ne), 64'(exp_n));
    chk({tag, "_data_mismatches"}, 64'(mism), 64'd0);
    chk({tag, "_vec_ld_pulses"}, 64'(vec_ld_cnt - vld_base), 64'(exp_vld));
    chk({tag, "_cyc_o_closed"}, 64'(cyc_o), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      if ((k % 25) == 12) std_v[2*k +: 2] = ((k / 25) % 2 == 0) ? 2'b01 : 2'b10;
      else                std_v[2*k +: 2] = 2'b11;
    end
    ones_v = '1;
    zero_v = '0;

    rst = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
    dat_i = 32'hDEADBEEF; ack_i = 1'b1; alloc_vec = std_v;
    tick(); tick(); tick();
    @(posedge clk); #1;
    chk("rst_ack_o", 64'(ack_o), 64'd0);
    chk("rst_stb_o", 64'(stb_o), 64'd0);
    chk("rst_we_o", 64'(we_o), 64'd0);
    chk("rst_cyc_o", 64'(cyc_o), 64'd0);
    chk("rst_dat_o", 64'(dat_o), 64'd0);
    chk("rst_vec_ld", 64'(vec_ld), 64'd0);
    tick();
    rst = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    tick();

    // Run A: 10 standard symbols, downstream always ready.
    start_run();
    ack_slow = 1'b0;
    chk("a_cyc_o_idle", 64'(cyc_o), 64'd0);
    for (int s = 0; s < 10; s++) begin
      for (int k = 0; k < N; k++) begin
        send_k(1, s, k, std_v);
        if (s == 0 && k == 0) begin
          @(posedge clk); #1;
          chk("a_latency_stb", 64'(stb_o), 64'd1);
          chk("a_latency_dat", 64'(dat_o), 64'(32'h0100_0000));
          chk("a_cyc_o_rise", 64'(cyc_o), 64'd1);
        end
      end
    end
    drain();
    check_run("a", 1920, 10);

    // Run B: same stream, downstream ready one cycle in three.
    start_run();
    ack_slow = 1'b1;
    for (int s = 0; s < 10; s++)
      for (int k = 0; k < N; k++) send_k(2, s, k, std_v);
    drain();
    check_run("b", 1920, 10);
    chk("b_ack_while_full", 64'(viol - viol_base), 64'd0);
    chk("b_fifo_reached_full", 64'((full_cnt - full_base) > 0), 64'd1);
    ack_slow = 1'b0;

    // Run C: strobe gap of 5 cycles at k=100 with the cycle held open.
    start_run();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < N; k++) begin
        if (s == 0 && k == 100) begin
          idle_cyc(3);
          #2;
          chk("c_gap_ack_o", 64'(ack_o), 64'd0);
          idle_cyc(2);
        end
        send_k(3, s, k, std_v);
      end
    end
    drain();
    check_run("c", 384, 2);

    // Run D: everything null, nothing goes downstream.
    start_run();
    alloc_vec = zero_v;
    for (int k = 0; k < N; k++) send_k(4, 0, k, zero_v);
    drain();
    check_run("d", 0, 1);
    chk("d_cyc_o_never", 64'(cyc_o_hi - cyc_base), 64'd0);
    chk("d_no_stalls", 64'(stalls - stall_base), 64'd0);
    alloc_vec = std_v;

    // Run E: reset pulsed mid-symbol at k=100.
    for (int k = 0; k < 100; k++) send_k(5, 0, k, std_v);
    tick();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("e_rst_ack_o", 64'(ack_o), 64'd0);
    chk("e_rst_stb_o", 64'(stb_o), 64'd0);
    chk("e_rst_cyc_o", 64'(cyc_o), 64'd0);
    chk("e_rst_dat_o", 64'(dat_o), 64'd0);
    chk("e_rst_vec_ld", 64'(vec_ld), 64'd0);
    start_run();
    tick();
    rst = 1'b0; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
    dat_i = 32'h0501_0000; cur_is_data = 1'b1;
    #2;
    chk("e_first_vec_ld", 64'(vec_ld), 64'd1);
    chk("e_first_ack_o", 64'(ack_o), 64'd1);
    exp_q.push_back(32'h0501_0000);
    for (int k = 1; k < N; k++) send_k(5, 1, k, std_v);
    drain();
    check_run("e", 192, 1);

    // Run F: vector switched to all-data at k=50; applies from next symbol.
    start_run();
    for (int k = 0; k < N; k++) begin
      if (k == 50) alloc_vec = ones_v;
      send_k(6, 0, k, std_v);
    end
    for (int k = 0; k < N; k++) send_k(6, 1, k, ones_v);
    drain();
    check_run("f", 392, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_extract.md
DATA_EXTRACT -- requirements
Module: data_extract

Interface
REQ-001 SHALL have parameter NSC, default 200, meaning used subcarriers per OFDM symbol.
REQ-002 SHALL have parameter DW, default 32, meaning sample width {Im[31:16], Re[15:0]}, signed two's complement.
REQ-003 SHALL have port CLK_I  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RST_I  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port DAT_I  in  DW  phase-tracked subcarrier sample from PhaseTrack DAT_O.
REQ-006 SHALL have ports CYC_I, STB_I, WE_I  in  1 each  upstream bus cycle, strobe and write qualifiers.
REQ-007 SHALL have port ACK_O  out  1  input sample accepted this cycle.
REQ-008 SHALL have port DAT_O  out  DW  data-subcarrier sample.
REQ-009 SHALL have ports CYC_O, STB_O, WE_O  out  1 each  downstream bus cycle, strobe and write qualifiers.
REQ-010 SHALL have port ACK_I  in  1  downstream accepted DAT_O.
REQ-011 SHALL have port ALLOC_VEC  in  2*NSC  per-subcarrier code; subcarrier k uses bits [2k+1:2k].
REQ-012 SHALL have port VEC_LD  out  1  one-cycle pulse when ALLOC_VEC is sampled.

Function
REQ-013 Codes SHALL be: 11 data; 01 pilot +1; 10 pilot -1; 00 null.
REQ-014 Input transfer SHALL occur when CYC_I & STB_I & WE_I & ACK_O; ACK_O = CYC_I & STB_I & WE_I & (buffer count < 2); no combinational path from ACK_I to ACK_O.
REQ-015 Subcarrier index k SHALL start at 0, increment per input transfer, wrap NSC-1 -> 0; held while STB_I is low and CYC_I is high.
REQ-016 On the input transfer with k==0, ALLOC_VEC SHALL be latched internally, and VEC_LD SHALL pulse in that same cycle; index 0 is classified with the new vector.
REQ-017 ALLOC_VEC changes mid-symbol SHALL take effect only at the next k==0.
REQ-018 Samples with code 11 SHALL be pushed unchanged into a 2-entry FIFO; all other codes SHALL be acknowledged and dropped.
REQ-019 STB_O = WE_O = FIFO not empty; DAT_O = FIFO head; pop on STB_O & ACK_I; push and pop in the same cycle are allowed.
REQ-020 Latency from an accepted data sample to STB_O with DAT_O equal to that sample SHALL be 1 cycle when the FIFO is empty.
REQ-021 CYC_O SHALL rise with the first STB_O of a frame, and fall the cycle after CYC_I is low and the FIFO is empty.
REQ-022 CYC_I low SHALL reset k to 0; a partial symbol is discarded from counting, and already-buffered data still drains.
REQ-023 Sample order SHALL be preserved; there SHALL be no loss or duplication under any ACK_I pattern.

Reset
REQ-024 While RST_I is high, at the next edge: ACK_O, STB_O, WE_O, CYC_O, VEC_LD = 0; DAT_O = 0; FIFO empty; k = 0; latched vector = 0.
REQ-025 Reset mid-symbol SHALL discard FIFO contents; the first transfer after reset is treated as index 0.

Structure
REQ-026 Shared package ofdm_pkg SHALL hold NSC, DW, and the code constants ALLOC_NULL/PILOT_P/PILOT_N/DATA.
REQ-027 The 2-entry FIFO SHALL be a separate sub-module wb_skid_fifo (params DW, depth 2; ports push/pop/full/empty/count).
REQ-028 The index counter, vector latch and classification SHALL be in data_extract.

Verification
REQ-029 10 symbols x 200 samples, standard vector (pilots at k=12,37,62,87,112,137,162,187, rest data), ACK_I=1 -> exactly 1920 outputs matching the input sequence minus pilots; VEC_LD pulses 10 times.
REQ-030 Same stimulus with ACK_I high 1 cycle in 3 -> identical 1920-word output; ACK_O low whenever the FIFO holds 2 entries.
REQ-031 STB_I low for 5 cycles at k=100 with CYC_I high -> k holds at 100; output identical to the gap-free run.
REQ-032 ALLOC_VEC all 00 -> no STB_O; CYC_O stays 0; ACK_O accepts every sample.
REQ-033 RST_I pulsed at k=100 -> all outputs 0 next cycle; next transfer gives VEC_LD=1 and is treated as index 0.
REQ-034 ALLOC_VEC switched to all-11 at k=50 -> current symbol still drops pilots; next symbol yields 200 outputs.
